// File: rtl/johnson_rx_monitor_if.sv
// Bus bundle for the Johnson receive monitor: sampled code word in,
// decoded index and status/error indications out.
interface johnson_rx_monitor_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(2*N);

  logic          in_valid;
  logic [N-1:0]  johnson_in;
  logic [IW-1:0] index;
  logic          index_valid;
  logic          illegal;
  logic          seq_err;
  logic          locked;
  logic [7:0]    err_count;

  modport master (
    output in_valid, johnson_in,
    input  index, index_valid, illegal, seq_err, locked, err_count
  );

  modport slave (
    input  in_valid, johnson_in,
    output index, index_valid, illegal, seq_err, locked, err_count
  );
endinterface

// File: rtl/johnson_rx_monitor.sv
// Receive-side Johnson code checker: decodes each valid word to a step index,
// flags illegal codes, tracks single-step advance and locks after LOCK_CNT good steps.
module johnson_rx_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic               clk,
  input  logic               reset,
  johnson_rx_monitor_if.slave bus
);
  localparam int IW  = $clog2(2*N);
  localparam int SEQ = 2*N;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state, state_n;
  logic [3:0]    mcnt, mcnt_n;
  logic [IW-1:0] prev, prev_n;
  logic [IW-1:0] index_q;
  logic          index_valid_q, illegal_q, seq_err_q, locked_q;
  logic [7:0]    err_count_q;

  logic [N-1:0]  q;
  logic [N-1:0]  lo_mask, hi_mask;
  int            pc;
  logic          legal;
  logic [IW-1:0] dec_idx, exp_idx;
  logic          step_ok;
  logic          err_ev;

  assign q = bus.johnson_in;

  // A legal word is all-zero or a contiguous run of ones anchored at either end,
  // so it must equal one of the two masks built from its own popcount.
  always_comb begin
    pc      = 0;
    lo_mask = '0;
    hi_mask = '0;
    for (int i = 0; i < N; i++) pc += int'(q[i]);
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (i < pc);
      hi_mask[i] = (i >= N - pc);
    end
    legal = (q == lo_mask) || (q == hi_mask);
    if (q[N-1] || (q == '0)) dec_idx = IW'(pc);
    else                      dec_idx = IW'(SEQ - pc);
  end

  // Explicit wrap keeps this correct when 2N is not a power of two.
  assign exp_idx = (prev == IW'(SEQ-1)) ? '0 : prev + 1'b1;
  assign step_ok = legal && (dec_idx == exp_idx);

  always_comb begin
    state_n = state;
    mcnt_n  = mcnt;
    prev_n  = prev;
    err_ev  = 1'b0;
    if (bus.in_valid) begin
      if (legal) prev_n = dec_idx;
      case (state)
        IDLE: begin
          if (legal) begin
            mcnt_n  = '0;
            state_n = TRACK;
          end
        end
        TRACK: begin
          if (!legal) begin
            state_n = IDLE;
          end else if (step_ok) begin
            mcnt_n = mcnt + 1'b1;
            if (mcnt_n == 4'(LOCK_CNT)) state_n = LOCKED;
          end else begin
            mcnt_n = '0;
          end
        end
        LOCKED: begin
          if (!legal) begin
            err_ev  = 1'b1;
            state_n = IDLE;
          end else if (!step_ok) begin
            err_ev  = 1'b1;
            mcnt_n  = '0;
            state_n = TRACK;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      mcnt          <= '0;
      prev          <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state         <= state_n;
      mcnt          <= mcnt_n;
      prev          <= prev_n;
      index_valid_q <= bus.in_valid && legal;
      illegal_q     <= bus.in_valid && !legal;
      seq_err_q     <= err_ev;
      locked_q      <= (state_n == LOCKED);
      if (bus.in_valid && legal) index_q <= dec_idx;
      if (err_ev && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.illegal     = illegal_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.locked      = locked_q;
  assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_johnson_rx_monitor.sv
// Directed bench for johnson_rx_monitor (N=4, LOCK_CNT=3) with hand-computed expectations.
module tb_johnson_rx_monitor;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   p;

  johnson_rx_monitor_if #(.N(4)) bus ();

  johnson_rx_monitor #(.N(4), .LOCK_CNT(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] word_of(int i);
    case (i % 8)
      0: return 4'b0000;
      1: return 4'b1000;
      2: return 4'b1100;
      3: return 4'b1110;
      4: return 4'b1111;
      5: return 4'b0111;
      6: return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic chk(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(string tag, int idx, int iv, int ill, int se, int lk, int ec);
    chk({tag, ".index"},       int'(bus.index),       idx);
    chk({tag, ".index_valid"}, int'(bus.index_valid), iv);
    chk({tag, ".illegal"},     int'(bus.illegal),     ill);
    chk({tag, ".seq_err"},     int'(bus.seq_err),     se);
    chk({tag, ".locked"},      int'(bus.locked),      lk);
    chk({tag, ".err_count"},   int'(bus.err_count),   ec);
  endtask

  // Present one input at a negedge; the following negedge shows the registered result.
  task automatic drive(logic v, logic [3:0] w);
    bus.in_valid   = v;
    bus.johnson_in = w;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b1;
    bus.johnson_in = 4'($urandom);
    @(negedge clk);
    chk_out("rst0", 0, 0, 0, 0, 0, 0);
    bus.johnson_in = 4'($urandom);
    @(negedge clk);
    chk_out("rst1", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Clean acquisition
    drive(1, 4'b0000); chk_out("acq0", 0, 1, 0, 0, 0, 0);
    drive(1, 4'b1000); chk_out("acq1", 1, 1, 0, 0, 0, 0);
    drive(1, 4'b1100); chk_out("acq2", 2, 1, 0, 0, 0, 0);
    drive(1, 4'b1110); chk_out("acq3", 3, 1, 0, 0, 1, 0);

    // Wrap-around while locked
    drive(1, 4'b1111); chk_out("wrap4", 4, 1, 0, 0, 1, 0);
    drive(1, 4'b0111); chk_out("wrap5", 5, 1, 0, 0, 1, 0);
    drive(1, 4'b0011); chk_out("wrap6", 6, 1, 0, 0, 1, 0);
    drive(1, 4'b0001); chk_out("wrap7", 7, 1, 0, 0, 1, 0);
    drive(1, 4'b0000); chk_out("wrap0", 0, 1, 0, 0, 1, 0);
    drive(1, 4'b1000); chk_out("wrap1", 1, 1, 0, 0, 1, 0);

    // Skipped step while locked, then relock from TRACK
    drive(1, 4'b1100); chk_out("skip2", 2, 1, 0, 0, 1, 0);
    drive(1, 4'b1111); chk_out("skip4", 4, 1, 0, 1, 0, 1);
    drive(1, 4'b0111); chk_out("rel5",  5, 1, 0, 0, 0, 1);
    drive(1, 4'b0011); chk_out("rel6",  6, 1, 0, 0, 0, 1);
    drive(1, 4'b0001); chk_out("rel7",  7, 1, 0, 0, 1, 1);

    // Illegal word while locked: index holds, falls back to IDLE
    drive(1, 4'b1010); chk_out("ill",   7, 0, 1, 1, 0, 2);
    // From IDLE an illegal word raises no seq_err; a repeated word in TRACK resets the run
    drive(1, 4'b0101); chk_out("idle_ill", 7, 0, 1, 0, 0, 2);
    drive(1, 4'b0000); chk_out("g0", 0, 1, 0, 0, 0, 2);
    drive(1, 4'b0000); chk_out("rep0", 0, 1, 0, 0, 0, 2);
    drive(1, 4'b1000); chk_out("g1", 1, 1, 0, 0, 0, 2);
    drive(1, 4'b1100); chk_out("g2", 2, 1, 0, 0, 0, 2);
    drive(1, 4'b1110); chk_out("g3", 3, 1, 0, 0, 1, 2);

    // Bubbles between steps leave lock intact
    drive(0, 4'b1010); chk_out("gap_a", 3, 0, 0, 0, 1, 2);
    drive(1, 4'b1111); chk_out("g4",    4, 1, 0, 0, 1, 2);
    drive(0, 4'b0000); chk_out("gap_b", 4, 0, 0, 0, 1, 2);
    drive(0, 4'b0000); chk_out("gap_c", 4, 0, 0, 0, 1, 2);
    drive(1, 4'b0111); chk_out("g5",    5, 1, 0, 0, 1, 2);

    // 300 wrong-step errors, each followed by a relock
    p = 5;
    for (int k = 0; k < 300; k++) begin
      drive(1, word_of(p + 2));
      drive(1, word_of(p + 3));
      drive(1, word_of(p + 4));
      drive(1, word_of(p + 5));
      p = (p + 5) % 8;
    end
    chk_out("sat", p, 1, 0, 0, 1, 255);
    drive(1, word_of(p + 3)); chk_out("sat_hold", (p + 3) % 8, 1, 0, 1, 0, 255);
    p = (p + 3) % 8;
    drive(1, word_of(p + 1));
    drive(1, word_of(p + 2));
    drive(1, word_of(p + 3));
    chk_out("sat_relock", (p + 3) % 8, 1, 0, 0, 1, 255);

    // Asynchronous reset mid-lock, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst.err_count", int'(bus.err_count), 0);
    chk("arst.locked",    int'(bus.locked),    0);
    chk("arst.index",     int'(bus.index),     0);
    @(negedge clk);
    rst_n = 1'b1;

    // After release the block is in IDLE: illegal gives no seq_err, legal enters TRACK
    drive(1, 4'b1010); chk_out("post_ill", 0, 0, 1, 0, 0, 0);
    drive(1, 4'b1100); chk_out("post2",    2, 1, 0, 0, 0, 0);
    drive(1, 4'b1110); chk_out("post3",    3, 1, 0, 0, 0, 0);
    drive(0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
